// File: rtl/response_serializer.sv
// Read-response serializer: captures {RESP_CMD, addr, value} and streams it
// word by word (MSW first) over a valid/ready handshake toward the byte TX.
module response_serializer #(
   parameter int                    WORD_WIDTH  = 8,
   parameter int                    VALUE_WORDS = 4,
   parameter logic [WORD_WIDTH-1:0] RESP_CMD    = 8'h72
) (
   input  logic                              clk,
   input  logic                              i_reset,
   input  logic                              i_r_valid,
   input  logic [WORD_WIDTH-1:0]             i_addr,
   input  logic [WORD_WIDTH*VALUE_WORDS-1:0] i_value,
   output logic [WORD_WIDTH-1:0]             o_tx_data,
   output logic                              o_tx_dv,
   input  logic                              i_tx_ready,
   output logic                              o_busy,
   output logic                              o_done,
   output logic                              o_overrun
);

   localparam int FRAME_WORDS = VALUE_WORDS + 2;
   localparam int FW          = FRAME_WORDS * WORD_WIDTH;
   localparam int CW          = $clog2(VALUE_WORDS + 3);
   localparam logic [CW-1:0] LOAD_COUNT = CW'(FRAME_WORDS);

   typedef enum logic {IDLE, SEND} state_t;

   state_t          state, state_nxt;
   logic [FW-1:0]   shreg;
   logic [CW-1:0]   count;
   logic            done_q;
   logic            overrun_q;
   logic            last_word;

   assign last_word = (count == CW'(1));

   // State register and datapath.
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values, independent of statement order.
   always_ff @(posedge clk) begin
      if (i_reset) begin
         state     <= IDLE;
         shreg     <= '0;
         count     <= '0;
         done_q    <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         state     <= state_nxt;
         done_q    <= 1'b0;
         overrun_q <= 1'b0;
         case (state)
            IDLE: begin
               if (i_r_valid) begin
                  shreg <= {RESP_CMD, i_addr, i_value};
                  count <= LOAD_COUNT;
               end
            end
            SEND: begin
               overrun_q <= i_r_valid;
               if (i_tx_ready) begin
                  shreg <= {shreg[FW-WORD_WIDTH-1:0], {WORD_WIDTH{1'b0}}};
                  count <= count - CW'(1);
                  done_q <= last_word;
               end
            end
            default: ;
         endcase
      end
   end

   // Next-state logic.
   // NOTE: defaulting state_nxt before the case keeps this purely combinational
   // (no latch) even on paths that do not assign it.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (i_r_valid) state_nxt = SEND;
         SEND:    if (i_tx_ready && last_word) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Outputs depend only on registered state; i_tx_ready never reaches o_tx_dv.
   always_comb begin
      o_tx_dv   = (state == SEND);
      o_busy    = (state == SEND);
      o_tx_data = (state == SEND) ? shreg[FW-1 -: WORD_WIDTH] : '0;
      o_done    = done_q;
      o_overrun = overrun_q;
   end

endmodule

// File: tb/tb_response_serializer.sv
// Directed self-checking bench for response_serializer (8-bit words, 4 value words).
module tb_response_serializer;

   logic        clk = 1'b0;
   logic        i_reset;
   logic        i_r_valid;
   logic [7:0]  i_addr;
   logic [31:0] i_value;
   logic [7:0]  o_tx_data;
   logic        o_tx_dv;
   logic        i_tx_ready;
   logic        o_busy;
   logic        o_done;
   logic        o_overrun;

   int checks = 0;
   int errors = 0;
   int ovr_seen;
   int done_seen;

   always #5 clk = ~clk;

   response_serializer dut (
      .clk        (clk),
      .i_reset    (i_reset),
      .i_r_valid  (i_r_valid),
      .i_addr     (i_addr),
      .i_value    (i_value),
      .o_tx_data  (o_tx_data),
      .o_tx_dv    (o_tx_dv),
      .i_tx_ready (i_tx_ready),
      .o_busy     (o_busy),
      .o_done     (o_done),
      .o_overrun  (o_overrun)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Advance to just after the next rising edge; inputs and samples live here.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_idle(input string tag);
      check({tag, " dv"},      32'(o_tx_dv),   0);
      check({tag, " data"},    32'(o_tx_data), 0);
      check({tag, " busy"},    32'(o_busy),    0);
      check({tag, " done"},    32'(o_done),    0);
      check({tag, " overrun"}, 32'(o_overrun), 0);
   endtask

   task automatic request(input logic [7:0] addr, input logic [31:0] value);
      i_r_valid = 1'b1;
      i_addr    = addr;
      i_value   = value;
      tick();
      i_r_valid = 1'b0;
   endtask

   // Receive one frame: ready asserted every `period`-th cycle, optional
   // i_r_valid pulse while word index ovr_word is pending. Ends in the cycle
   // after the last handshake and checks the o_done pulse there.
   task automatic recv_frame(input string name, input logic [47:0] exp,
                             input int period, input int ovr_word);
      int got = 0;
      int cyc = 0;
      bit pulsed = 0;
      bit hold_valid = 0;
      logic [7:0] held = '0;
      ovr_seen  = 0;
      done_seen = 0;
      while (got < 6 && cyc < 100) begin
         i_tx_ready = ((cyc % period) == period - 1);
         if (got == ovr_word && !pulsed) begin
            i_r_valid = 1'b1;
            i_addr    = 8'h09;
            pulsed    = 1;
         end else begin
            i_r_valid = 1'b0;
         end
         if (o_overrun) ovr_seen++;
         if (o_done)    done_seen++;
         check({name, " dv continuous"}, 32'(o_tx_dv), 1);
         check({name, " busy"},          32'(o_busy),  1);
         if (hold_valid) check({name, " data stable"}, 32'(o_tx_data), 32'(held));
         if (i_tx_ready) begin
            check($sformatf("%s word%0d", name, got), 32'(o_tx_data),
                  32'(exp[47 - 8*got -: 8]));
            got++;
            hold_valid = 0;
         end else begin
            held       = o_tx_data;
            hold_valid = 1;
         end
         tick();
         cyc++;
      end
      i_tx_ready = 1'b0;
      i_r_valid  = 1'b0;
      check({name, " words received"}, 32'(got), 6);
      if (o_overrun) ovr_seen++;
      check({name, " done after last"}, 32'(o_done),  1);
      check({name, " busy at done"},    32'(o_busy),  0);
      check({name, " dv at done"},      32'(o_tx_dv), 0);
      check({name, " data at done"},    32'(o_tx_data), 0);
      check({name, " no early done"},   32'(done_seen), 0);
   endtask

   initial begin
      i_reset    = 1'b1;
      i_r_valid  = 1'b0;
      i_addr     = '0;
      i_value    = '0;
      i_tx_ready = 1'b0;
      tick();
      tick();
      check_idle("reset");
      i_reset = 1'b0;
      tick();
      check_idle("post reset");

      // 1 Basic frame, ready held high; first word right after acceptance
      i_tx_ready = 1'b1;
      request(8'h05, 32'hDEADBEEF);
      check("basic first word", 32'(o_tx_data), 32'h72);
      recv_frame("basic", 48'h7205DEADBEEF, 1, -1);
      tick();
      check("basic done single", 32'(o_done), 0);
      check_idle("basic after");

      // 2 Backpressure: ready every 3rd cycle
      request(8'h05, 32'hDEADBEEF);
      recv_frame("bp", 48'h7205DEADBEEF, 3, -1);
      tick();
      check_idle("bp after");

      // 3 Overrun during byte 3; no second frame may follow
      request(8'h05, 32'hDEADBEEF);
      recv_frame("ovr", 48'h7205DEADBEEF, 1, 2);
      check("ovr pulse count", 32'(ovr_seen), 1);
      for (int i = 0; i < 4; i++) begin
         tick();
         check("ovr no second frame", 32'(o_tx_dv), 0);
         check("ovr no repeat", 32'(o_overrun), 0);
      end

      // 4 Back-to-back: new request in the o_done cycle
      request(8'h05, 32'hDEADBEEF);
      recv_frame("b2b first", 48'h7205DEADBEEF, 1, -1);
      request(8'h10, 32'h01234567);
      recv_frame("b2b second", 48'h721001234567, 1, -1);
      tick();
      check_idle("b2b after");

      // 5 Reset mid-frame after two words
      request(8'h05, 32'hDEADBEEF);
      i_tx_ready = 1'b1;
      tick();
      tick();
      check("rst third word pending", 32'(o_tx_data), 32'hDE);
      i_tx_ready = 1'b0;
      i_reset    = 1'b1;
      tick();
      i_reset = 1'b0;
      check_idle("rst mid-frame");
      for (int i = 0; i < 3; i++) begin
         tick();
         check("rst no done", 32'(o_done), 0);
         check("rst no dv", 32'(o_tx_dv), 0);
      end
      request(8'h33, 32'hA5C3_0F81);
      recv_frame("rst recover", 48'h7233A5C30F81, 1, -1);

      // 6 Input change after acceptance does not affect the frame
      tick();
      request(8'h44, 32'h1122_3344);
      i_addr  = 8'hFF;
      i_value = 32'hFFFF_FFFF;
      recv_frame("hold inputs", 48'h724411223344, 2, -1);
      tick();
      check_idle("final");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
